rtc_apb_initiator: RTL and testbench

RTC_APB_INITIATOR -- requirements
Module: rtc_apb_initiator

---
 rtl/rtc_apb_pkg.sv | 24 ++
 rtl/rtc_apb_initiator_if.sv | 40 ++++
 rtl/rtc_apb_timeout.sv | 37 +++
 rtl/rtc_apb_initiator.sv | 101 ++++++++++
 tb/tb_rtc_apb_initiator.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_apb_pkg.sv
// Shared types and constants for the APB initiator slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, APB bus widths, default timeout, counter width helper.
package rtc_apb_pkg;

  localparam int APB_ADDR_W      = 10;
  localparam int APB_DATA_W      = 32;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  // Width able to hold 0..limit; kept at least 1 bit so a disabled
  // timeout (limit 0) still yields a legal vector.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rtc_apb_initiator_if.sv
// Host command/response channel plus APB requester bus, bundled.
// Latency: n/a (wiring only).
// Backpressure: CmdValid/CmdReady on commands, RspValid/RspReady on responses, PREADY on APB.
// Modports: master = the initiator, slave = host and APB responder side.
interface rtc_apb_initiator_if;
  import rtc_apb_pkg::*;

  // host command channel
  logic                  CmdValid;
  logic                  CmdReady;
  logic                  CmdWrite;
  logic [APB_ADDR_W-1:0] CmdAddr;
  logic [APB_DATA_W-1:0] CmdWdata;
  // host response channel
  logic                  RspValid;
  logic                  RspReady;
  logic [APB_DATA_W-1:0] RspRdata;
  logic                  RspError;
  // APB requester side
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_ADDR_W-1:0] PADDR;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;

  modport master (
    input  CmdValid, CmdWrite, CmdAddr, CmdWdata, RspReady, PRDATA, PREADY,
    output CmdReady, RspValid, RspRdata, RspError,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output CmdValid, CmdWrite, CmdAddr, CmdWdata, RspReady, PRDATA, PREADY,
    input  CmdReady, RspValid, RspRdata, RspError,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/rtc_apb_timeout.sv
// Saturating wait-state counter with clear, enable and limit-hit flag.
// Latency: hit is combinational on the cycle whose increment reaches LIMIT.
// Backpressure: none; LIMIT = 0 disables (hit never asserts).
// Ports: clk, rst_n, clr (restart at 0), en (count this cycle), hit.
module rtc_apb_timeout
  import rtc_apb_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LIMIT);
  localparam logic [CW-1:0] CNT_LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires on the wait cycle that would take the count to LIMIT, so the
  // FSM leaves ACCESS after exactly LIMIT stalled cycles.
  assign hit = (LIMIT > 0) && en && (cnt == CNT_LAST);

endmodule

// File: rtl/rtc_apb_initiator.sv
// Converts host commands into single APB transfers and returns a response.
// Latency: accept edge k -> SETUP k+1 -> ACCESS k+2 -> RspValid from k+3 (zero wait states).
// Backpressure: CmdReady only in IDLE; response held until RspReady; PREADY stalls ACCESS up to TIMEOUT_CYCLES.
// Ports: PCLK, PRESETn (async, active-low), bus (master modport: host cmd/rsp + APB).
module rtc_apb_initiator
  import rtc_apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  rtc_apb_initiator_if.master  bus
);

  state_t state;
  logic   to_clr;
  logic   to_en;
  logic   to_hit;

  // Counter restarts on the edge that moves IDLE -> SETUP and only counts
  // ACCESS cycles that the responder stalls.
  assign to_clr = (state == ST_IDLE) && bus.CmdValid;
  assign to_en  = (state == ST_ACCESS) && !bus.PREADY;

  rtc_apb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clr   (to_clr),
    .en    (to_en),
    .hit   (to_hit)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state        <= ST_IDLE;
      bus.CmdReady <= 1'b1;
      bus.RspValid <= 1'b0;
      bus.RspRdata <= '0;
      bus.RspError <= 1'b0;
      bus.PSEL     <= 1'b0;
      bus.PENABLE  <= 1'b0;
      bus.PWRITE   <= 1'b0;
      bus.PADDR    <= '0;
      bus.PWDATA   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.CmdValid) begin
            bus.PWRITE   <= bus.CmdWrite;
            bus.PADDR    <= bus.CmdAddr;
            bus.PWDATA   <= bus.CmdWrite ? bus.CmdWdata : '0;
            bus.PSEL     <= 1'b1;
            bus.CmdReady <= 1'b0;
            state        <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ST_ACCESS;
        end

        ST_ACCESS: begin
          // PREADY wins over a timeout landing on the same cycle.
          if (bus.PREADY) begin
            bus.PSEL     <= 1'b0;
            bus.PENABLE  <= 1'b0;
            bus.RspValid <= 1'b1;
            bus.RspRdata <= bus.PWRITE ? '0 : bus.PRDATA;
            bus.RspError <= 1'b0;
            state        <= ST_RESP;
          end else if (to_hit) begin
            bus.PSEL     <= 1'b0;
            bus.PENABLE  <= 1'b0;
            bus.RspValid <= 1'b1;
            bus.RspRdata <= '0;
            bus.RspError <= 1'b1;
            state        <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (bus.RspReady) begin
            bus.RspValid <= 1'b0;
            bus.RspRdata <= '0;
            bus.RspError <= 1'b0;
            bus.CmdReady <= 1'b1;
            state        <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_apb_initiator.sv
// Directed bench for rtc_apb_initiator with hand-computed expectations.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Covers reset, write/read, wait states, timeout, boundary, backpressure, mid-transfer reset.
module tb_rtc_apb_initiator;

  logic PCLK;
  logic PRESETn;
  int   compared   = 0;
  int   mismatched = 0;
  int   acc;

  rtc_apb_initiator_if bus ();

  rtc_apb_initiator #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Walks ACCESS cycles; PREADY low for the first lowcnt of them.
  task automatic run_access(input int lowcnt, output int n);
    n = 0;
    while (bus.PSEL && bus.PENABLE && n < 40) begin
      n++;
      bus.PREADY = (n > lowcnt);
      tick();
    end
    bus.PREADY = 1'b1;
  endtask

  task automatic rsp_handshake();
    bus.RspReady = 1'b1;
    tick();
    bus.RspReady = 1'b0;
  endtask

  initial begin
    PRESETn      = 1'b0;
    bus.CmdValid = 1'b0;
    bus.CmdWrite = 1'b0;
    bus.CmdAddr  = '0;
    bus.CmdWdata = '0;
    bus.RspReady = 1'b0;
    bus.PRDATA   = '0;
    bus.PREADY   = 1'b1;
    repeat (3) tick();

    // reset state
    chk("rst_psel",    32'(bus.PSEL),     32'd0);
    chk("rst_penable", 32'(bus.PENABLE),  32'd0);
    chk("rst_pwrite",  32'(bus.PWRITE),   32'd0);
    chk("rst_paddr",   32'(bus.PADDR),    32'd0);
    chk("rst_pwdata",  bus.PWDATA,        32'd0);
    chk("rst_rspval",  32'(bus.RspValid), 32'd0);
    chk("rst_rsperr",  32'(bus.RspError), 32'd0);
    chk("rst_rdata",   bus.RspRdata,      32'd0);
    PRESETn = 1'b1;
    tick();
    chk("rst_cmdrdy",  32'(bus.CmdReady), 32'd1);

    // zero-wait write: SETUP k+1, ACCESS k+2, RspValid k+3
    bus.CmdValid = 1'b1;
    bus.CmdWrite = 1'b1;
    bus.CmdAddr  = 10'h002;
    bus.CmdWdata = 32'h1234_5678;
    tick();
    bus.CmdValid = 1'b0;
    chk("wr_setup_psel", 32'(bus.PSEL),     32'd1);
    chk("wr_setup_pen",  32'(bus.PENABLE),  32'd0);
    chk("wr_paddr",      32'(bus.PADDR),    32'h002);
    chk("wr_pwdata",     bus.PWDATA,        32'h1234_5678);
    chk("wr_pwrite",     32'(bus.PWRITE),   32'd1);
    chk("wr_cmdrdy",     32'(bus.CmdReady), 32'd0);
    tick();
    chk("wr_access_psel", 32'(bus.PSEL),     32'd1);
    chk("wr_access_pen",  32'(bus.PENABLE),  32'd1);
    chk("wr_access_rv",   32'(bus.RspValid), 32'd0);
    chk("wr_access_pwd",  bus.PWDATA,        32'h1234_5678);
    tick();
    chk("wr_rsp_valid", 32'(bus.RspValid), 32'd1);
    chk("wr_rsp_psel",  32'(bus.PSEL),     32'd0);
    chk("wr_rsp_err",   32'(bus.RspError), 32'd0);
    chk("wr_rsp_rdata", bus.RspRdata,      32'd0);
    rsp_handshake();
    chk("wr_idle_rv",   32'(bus.RspValid), 32'd0);
    chk("wr_idle_rdy",  32'(bus.CmdReady), 32'd1);

    // read with 3 wait states -> 4 ACCESS cycles
    bus.PRDATA   = 32'hDEAD_BEEF;
    bus.CmdValid = 1'b1;
    bus.CmdWrite = 1'b0;
    bus.CmdAddr  = 10'h000;
    bus.CmdWdata = 32'hFFFF_FFFF;
    tick();
    bus.CmdValid = 1'b0;
    chk("rd_pwdata_zero", bus.PWDATA,      32'd0);
    chk("rd_pwrite",      32'(bus.PWRITE), 32'd0);
    tick();
    run_access(3, acc);
    chk("rd_access_cycles", 32'(acc),          32'd4);
    chk("rd_rsp_valid",     32'(bus.RspValid), 32'd1);
    chk("rd_rsp_rdata",     bus.RspRdata,      32'hDEAD_BEEF);
    chk("rd_rsp_err",       32'(bus.RspError), 32'd0);
    rsp_handshake();

    // PREADY never rises -> timeout after 16 ACCESS cycles
    bus.PRDATA   = 32'h5555_AAAA;
    bus.CmdValid = 1'b1;
    bus.CmdWrite = 1'b0;
    bus.CmdAddr  = 10'h155;
    tick();
    bus.CmdValid = 1'b0;
    tick();
    run_access(1000, acc);
    chk("to_access_cycles", 32'(acc),          32'd16);
    chk("to_rsp_valid",     32'(bus.RspValid), 32'd1);
    chk("to_rsp_err",       32'(bus.RspError), 32'd1);
    chk("to_rsp_rdata",     bus.RspRdata,      32'd0);
    chk("to_psel_low",      32'(bus.PSEL),     32'd0);
    chk("to_pen_low",       32'(bus.PENABLE),  32'd0);
    rsp_handshake();

    // PREADY on the 16th ACCESS cycle -> success
    bus.PRDATA   = 32'hCAFE_F00D;
    bus.CmdValid = 1'b1;
    bus.CmdAddr  = 10'h0AA;
    tick();
    bus.CmdValid = 1'b0;
    tick();
    run_access(15, acc);
    chk("edge_access_cycles", 32'(acc),          32'd16);
    chk("edge_rsp_err",       32'(bus.RspError), 32'd0);
    chk("edge_rsp_rdata",     bus.RspRdata,      32'hCAFE_F00D);
    rsp_handshake();

    // response backpressure with a second command held
    bus.CmdValid = 1'b1;
    bus.CmdWrite = 1'b1;
    bus.CmdAddr  = 10'h010;
    bus.CmdWdata = 32'h0000_0001;
    tick();
    bus.CmdWrite = 1'b0;
    bus.CmdAddr  = 10'h3FF;
    bus.CmdWdata = 32'h0;
    bus.PRDATA   = 32'h0BAD_F00D;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("bp_rsp_valid", 32'(bus.RspValid), 32'd1);
      chk("bp_rsp_err",   32'(bus.RspError), 32'd0);
      chk("bp_cmd_rdy",   32'(bus.CmdReady), 32'd0);
      chk("bp_psel",      32'(bus.PSEL),     32'd0);
      bus.RspReady = (i == 5);
      tick();
    end
    bus.RspReady = 1'b0;
    chk("bp_idle_rdy",  32'(bus.CmdReady), 32'd1);
    chk("bp_idle_rv",   32'(bus.RspValid), 32'd0);
    chk("bp_idle_psel", 32'(bus.PSEL),     32'd0);
    tick();
    bus.CmdValid = 1'b0;
    chk("bp2_setup_psel", 32'(bus.PSEL),   32'd1);
    chk("bp2_paddr",      32'(bus.PADDR),  32'h3FF);
    chk("bp2_pwrite",     32'(bus.PWRITE), 32'd0);
    tick();
    run_access(0, acc);
    chk("bp2_access_cycles", 32'(acc),     32'd1);
    chk("bp2_rsp_rdata",     bus.RspRdata, 32'h0BAD_F00D);
    rsp_handshake();

    // reset during ACCESS aborts with no response
    bus.PREADY   = 1'b0;
    bus.CmdValid = 1'b1;
    bus.CmdWrite = 1'b1;
    bus.CmdAddr  = 10'h004;
    bus.CmdWdata = 32'hA5A5_A5A5;
    tick();
    bus.CmdValid = 1'b0;
    tick();
    tick();
    chk("ar_in_access", 32'(bus.PENABLE), 32'd1);
    PRESETn = 1'b0;
    #1;
    chk("ar_psel",   32'(bus.PSEL),     32'd0);
    chk("ar_pen",    32'(bus.PENABLE),  32'd0);
    chk("ar_rspval", 32'(bus.RspValid), 32'd0);
    tick();
    PRESETn    = 1'b1;
    bus.PREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ar_no_rsp",  32'(bus.RspValid), 32'd0);
      chk("ar_no_psel", 32'(bus.PSEL),     32'd0);
      chk("ar_cmd_rdy", 32'(bus.CmdReady), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
